// File: rtl/rps_if.sv
// rps_if: move/start/verdict handshake between the match master and the referee.
interface rps_if;
  logic [1:0] p1_move;
  logic [1:0] p2_move;
  logic       start;
  logic [2:0] ref_state;
  logic [1:0] ref_winner;
  modport master (output p1_move, p2_move, start, input ref_state, ref_winner);
  modport slave (input p1_move, p2_move, start, output ref_state, ref_winner);
endinterface

// File: rtl/rps_match_master.sv
// rps_match_master: plays a best-of stone/paper/scissors match against the referee.
module rps_match_master #(
  parameter int         WIN_TARGET = 3,
  parameter int         MAX_ROUNDS = 15,
  parameter int         TIMEOUT    = 15,
  parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        match_go,
  input  logic [1:0]  p1_sel,
  input  logic        p1_rand,
  rps_if.master       bus,
  output logic [3:0]  p1_score,
  output logic [3:0]  p2_score,
  output logic [3:0]  tie_count,
  output logic [3:0]  round_cnt,
  output logic        busy,
  output logic        match_done,
  output logic [1:0]  match_winner,
  output logic        err_invalid,
  output logic        err_timeout
);
  typedef enum logic [2:0] {M_IDLE, M_LOAD, M_START, M_RELEASE, M_CHECK, M_DONE, M_ERR} state_t;
  state_t     state_q, state_d;
  logic [7:0] lfsr_q, lfsr_d;
  logic [1:0] p1_q, p1_d, p2_q, p2_d, verdict_q, verdict_d, winner_q, winner_d, alt;
  logic [3:0] p1s_q, p1s_d, p2s_q, p2s_d, ties_q, ties_d, rounds_q, rounds_d;
  logic [4:0] wait_q, wait_d;
  logic       inv_q, inv_d, to_q, to_d, advance;
  function automatic logic [3:0] inc(input logic [3:0] v);
    return v == 4'hf ? v : v + 4'd1;
  endfunction
  always_comb begin
    state_d   = state_q;
    lfsr_d    = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    p1_d      = p1_q;
    p2_d      = p2_q;
    verdict_d = verdict_q;
    winner_d  = winner_q;
    p1s_d     = p1s_q;
    p2s_d     = p2s_q;
    ties_d    = ties_q;
    rounds_d  = rounds_q;
    wait_d    = wait_q;
    inv_d     = inv_q;
    to_d      = to_q;
    // a random P1 draw of 11 is replaced by a move derived from P2's bits
    alt       = (lfsr_q[1:0] ^ 2'b01) == 2'b11 ? 2'b00 : lfsr_q[1:0] ^ 2'b01;
    advance   = state_q == M_START ? bus.ref_state == 3'b001 : bus.ref_state == 3'b000;
    case (state_q)
      M_IDLE, M_DONE, M_ERR: if (match_go) begin
        state_d  = M_LOAD;
        p1s_d    = '0;
        p2s_d    = '0;
        ties_d   = '0;
        rounds_d = '0;
        winner_d = '0;
        inv_d    = 1'b0;
        to_d     = 1'b0;
      end
      M_LOAD: if (lfsr_q[1:0] != 2'b11) begin
        p2_d    = lfsr_q[1:0];
        p1_d    = !p1_rand ? p1_sel : lfsr_q[3:2] != 2'b11 ? lfsr_q[3:2] : alt;
        wait_d  = '0;
        state_d = M_START;
      end
      M_START, M_RELEASE: if (advance) begin
        verdict_d = state_q == M_START ? bus.ref_winner : verdict_q;
        wait_d    = '0;
        state_d   = state_q == M_START ? M_RELEASE : M_CHECK;
      end else begin
        wait_d  = wait_q + 5'd1;
        state_d = wait_d == 5'(TIMEOUT) ? M_ERR : state_q;
        to_d    = wait_d == 5'(TIMEOUT);
      end
      M_CHECK: begin
        rounds_d = inc(rounds_q);
        p1s_d    = verdict_q == 2'b01 ? inc(p1s_q) : p1s_q;
        p2s_d    = verdict_q == 2'b10 ? inc(p2s_q) : p2s_q;
        ties_d   = verdict_q == 2'b00 ? inc(ties_q) : ties_q;
        inv_d    = inv_q | (verdict_q == 2'b11);
        winner_d = p1s_d == 4'(WIN_TARGET) ? 2'b01 : p2s_d == 4'(WIN_TARGET) ? 2'b10 : 2'b00;
        state_d  = (winner_d != 2'b00 || rounds_d == 4'(MAX_ROUNDS)) ? M_DONE : M_LOAD;
      end
      default: state_d = M_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= M_IDLE;
      lfsr_q    <= LFSR_SEED;
      p1_q      <= '0;
      p2_q      <= '0;
      verdict_q <= '0;
      winner_q  <= '0;
      p1s_q     <= '0;
      p2s_q     <= '0;
      ties_q    <= '0;
      rounds_q  <= '0;
      wait_q    <= '0;
      inv_q     <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      p1_q      <= p1_d;
      p2_q      <= p2_d;
      verdict_q <= verdict_d;
      winner_q  <= winner_d;
      p1s_q     <= p1s_d;
      p2s_q     <= p2s_d;
      ties_q    <= ties_d;
      rounds_q  <= rounds_d;
      wait_q    <= wait_d;
      inv_q     <= inv_d;
      to_q      <= to_d;
    end
  end
  assign bus.p1_move   = p1_q;
  assign bus.p2_move   = p2_q;
  assign bus.start     = state_q == M_START;
  assign p1_score      = p1s_q;
  assign p2_score      = p2s_q;
  assign tie_count     = ties_q;
  assign round_cnt     = rounds_q;
  assign busy          = state_q inside {M_LOAD, M_START, M_RELEASE, M_CHECK};
  assign match_done    = state_q == M_DONE;
  assign match_winner  = winner_q;
  assign err_invalid   = inv_q;
  assign err_timeout   = to_q;
endmodule
